sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM arbiter: read-only flash-emulation port A has default priority, user port B gets
// one-shot priority after USER_MAX_WAIT waiting cycles and is held off during A's critical window.
module sdram_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 16,
  parameter int USER_MAX_WAIT = 64,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_critical,
  input  logic                  spi_req,
  input  logic [ADDR_WIDTH-1:0] spi_addr,
  input  logic                  spi_refresh_inhibit,
  output logic                  spi_ack,
  input  logic                  user_req,
  input  logic                  user_we,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  input  logic [DATA_WIDTH-1:0] user_wr_data,
  input  logic [1:0]            user_wr_mask,
  output logic                  user_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  sd_enable,
  output logic                  sd_we,
  output logic [ADDR_WIDTH-1:0] sd_addr,
  output logic [DATA_WIDTH-1:0] sd_wr_data,
  output logic [1:0]            sd_wr_mask,
  output logic                  sd_refresh_inhibit,
  input  logic                  sd_ack_level,
  input  logic [DATA_WIDTH-1:0] sd_rd_data,
  output logic                  user_blocked,
  output logic [7:0]            error_count
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, RELEASE} state_t;

  localparam int SW = $clog2(USER_MAX_WAIT + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] A_FILL = DATA_WIDTH'(16'hDEAD);

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic [1:0]              wr_mask_q;
  logic                    ack_prev;
  logic [SW-1:0]           starve_cnt;
  logic                    starve_flag;
  logic [TW-1:0]           tmo_cnt;
  logic                    granted;
  logic                    ack_rise;
  logic                    grant_a;
  logic                    grant_b;
  logic                    timeout;
  logic                    starve_count_en;

  assign granted  = (state == GRANT_A) || (state == GRANT_B);
  assign ack_rise = sd_ack_level && !ack_prev;
  assign grant_b  = (state == IDLE) && user_req && !spi_critical && (!spi_req || starve_flag);
  assign grant_a  = (state == IDLE) && spi_req && !grant_b;
  assign timeout  = granted && !ack_rise && (tmo_cnt == TW'(ACK_TIMEOUT - 1));
  assign starve_count_en = user_req && !spi_critical && ((state == IDLE) || (state == GRANT_A));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_b)      state_next = GRANT_B;
        else if (grant_a) state_next = GRANT_A;
      end
      GRANT_A, GRANT_B: begin
        if (ack_rise || timeout) state_next = RELEASE;
      end
      RELEASE: begin
        if (!sd_ack_level) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sd_enable    = 1'b0;
    sd_we        = 1'b0;
    sd_wr_mask   = 2'b00;
    user_blocked = user_req && spi_critical && (state != GRANT_B);
    if (granted) begin
      sd_enable  = 1'b1;
      sd_we      = we_q;
      sd_wr_mask = wr_mask_q;
    end
  end

  assign sd_addr            = addr_q;
  assign sd_wr_data         = wr_data_q;
  assign sd_refresh_inhibit = spi_critical && spi_refresh_inhibit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      we_q        <= 1'b0;
      wr_data_q   <= '0;
      wr_mask_q   <= 2'b00;
      ack_prev    <= 1'b0;
      rd_data     <= '0;
      spi_ack     <= 1'b0;
      user_ack    <= 1'b0;
      tmo_cnt     <= '0;
      error_count <= 8'd0;
      starve_cnt  <= '0;
      starve_flag <= 1'b0;
    end else begin
      ack_prev <= sd_ack_level;
      if (grant_a) begin
        addr_q    <= spi_addr;
        we_q      <= 1'b0;
        wr_data_q <= A_FILL;
        wr_mask_q <= 2'b00;
      end else if (grant_b) begin
        addr_q    <= user_addr;
        we_q      <= user_we;
        wr_data_q <= user_wr_data;
        wr_mask_q <= user_wr_mask;
      end
      if (granted && ack_rise) rd_data <= sd_rd_data;
      spi_ack  <= (state == GRANT_A) && ack_rise;
      user_ack <= (state == GRANT_B) && ack_rise;
      tmo_cnt  <= granted ? tmo_cnt + TW'(1) : '0;
      if (timeout && (error_count != 8'hFF)) error_count <= error_count + 8'd1;
      // Waiting is frozen (not cleared) while A holds its critical window.
      if (grant_b) begin
        starve_cnt  <= '0;
        starve_flag <= 1'b0;
      end else if (starve_count_en) begin
        if (starve_cnt != SW'(USER_MAX_WAIT))     starve_cnt  <= starve_cnt + SW'(1);
        if (starve_cnt == SW'(USER_MAX_WAIT - 1)) starve_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small SDRAM-controller model acking a fixed latency after enable.
module tb_sdram_arbiter;

  localparam logic [15:0] DEAD = 16'hDEAD;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_critical, spi_req, spi_refresh_inhibit, spi_ack;
  logic [31:0] spi_addr;
  logic        user_req, user_we, user_ack;
  logic [31:0] user_addr;
  logic [15:0] user_wr_data;
  logic [1:0]  user_wr_mask;
  logic [15:0] rd_data;
  logic        sd_enable, sd_we, sd_refresh_inhibit;
  logic [31:0] sd_addr;
  logic [15:0] sd_wr_data;
  logic [1:0]  sd_wr_mask;
  logic        sd_ack_level;
  logic [15:0] sd_rd_data;
  logic        user_blocked;
  logic [7:0]  error_count;

  int tests = 0;
  int fails = 0;

  logic        ctrl_on = 1'b1;
  int          ctrl_lat = 3;
  logic [15:0] ctrl_data = 16'h0000;
  int          ccnt = 0;

  sdram_arbiter dut (
    .clk(clk), .reset(reset),
    .spi_critical(spi_critical), .spi_req(spi_req), .spi_addr(spi_addr),
    .spi_refresh_inhibit(spi_refresh_inhibit), .spi_ack(spi_ack),
    .user_req(user_req), .user_we(user_we), .user_addr(user_addr),
    .user_wr_data(user_wr_data), .user_wr_mask(user_wr_mask), .user_ack(user_ack),
    .rd_data(rd_data), .sd_enable(sd_enable), .sd_we(sd_we), .sd_addr(sd_addr),
    .sd_wr_data(sd_wr_data), .sd_wr_mask(sd_wr_mask), .sd_refresh_inhibit(sd_refresh_inhibit),
    .sd_ack_level(sd_ack_level), .sd_rd_data(sd_rd_data),
    .user_blocked(user_blocked), .error_count(error_count)
  );

  always #5 clk = ~clk;

  // Controller raises its ack level ctrl_lat cycles after enable, drops it once enable falls.
  always @(negedge clk) begin
    if (!ctrl_on || !sd_enable) begin
      sd_ack_level = 1'b0;
      ccnt = 0;
    end else if (!sd_ack_level) begin
      ccnt++;
      if (ccnt == ctrl_lat) begin
        sd_ack_level = 1'b1;
        sd_rd_data   = ctrl_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Returns the number of ticks until the selected ack is seen, or -1 if it never comes.
  task automatic wait_ack(input bit is_user, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if ((is_user ? user_ack : spi_ack) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    spi_critical = 0; spi_req = 0; spi_addr = '0; spi_refresh_inhibit = 0;
    user_req = 0; user_we = 0; user_addr = '0; user_wr_data = '0; user_wr_mask = '0;
    sd_ack_level = 0; sd_rd_data = '0;
    idle(3);
    tests++;
    if ({sd_enable, sd_we, spi_ack, user_ack, user_blocked, sd_refresh_inhibit, sd_wr_mask} !== 8'h00) begin
      fails++; $display("FAIL reset_ctrl got=%b exp=0", {sd_enable, sd_we, spi_ack, user_ack, user_blocked, sd_refresh_inhibit, sd_wr_mask});
    end
    tests++;
    if ({sd_addr, sd_wr_data, rd_data, error_count} !== 72'h0) begin
      fails++; $display("FAIL reset_data got=%h exp=0", {sd_addr, sd_wr_data, rd_data, error_count});
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_spi_read();
    int n;
    ctrl_on = 1; ctrl_lat = 3; ctrl_data = 16'h00A5;
    spi_addr = 32'h10; spi_req = 1;
    tick();
    tests++;
    if ({sd_enable, sd_we, sd_wr_mask} !== 4'b1000 || sd_addr !== 32'h10 || sd_wr_data !== DEAD) begin
      fails++; $display("FAIL spi_grant got=%b addr=%h wd=%h exp=1000 addr=10 wd=dead", {sd_enable, sd_we, sd_wr_mask}, sd_addr, sd_wr_data);
    end
    wait_ack(0, 20, n);
    tests++;
    if (n !== 3) begin fails++; $display("FAIL spi_ack_latency got=%0d exp=3", n); end
    tests++;
    if (rd_data !== 16'h00A5) begin fails++; $display("FAIL spi_rd_data got=%h exp=00a5", rd_data); end
    spi_req = 0;
    tick();
    tests++;
    if ({spi_ack, sd_enable} !== 2'b00) begin fails++; $display("FAIL spi_ack_pulse got=%b exp=00", {spi_ack, sd_enable}); end
    idle(4);
  endtask

  task automatic test_both_rise();
    int n;
    ctrl_data = 16'h1111;
    spi_addr = 32'h30; user_addr = 32'h20; user_we = 0;
    spi_req = 1; user_req = 1;
    tick();
    tests++;
    if (sd_enable !== 1'b1 || sd_addr !== 32'h30) begin fails++; $display("FAIL both_a_first en=%b addr=%h exp en=1 addr=30", sd_enable, sd_addr); end
    wait_ack(0, 20, n);
    tests++;
    if (n !== 3 || user_ack !== 1'b0) begin fails++; $display("FAIL both_a_ack got n=%0d uack=%b exp n=3 uack=0", n, user_ack); end
    spi_req = 0; ctrl_data = 16'h2222;
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (sd_enable === 1'b1) begin n = i; break; end
    end
    tests++;
    if (n !== 2 || sd_addr !== 32'h20) begin fails++; $display("FAIL both_b_after got n=%0d addr=%h exp n=2 addr=20", n, sd_addr); end
    wait_ack(1, 20, n);
    tests++;
    if (n !== 3 || rd_data !== 16'h2222) begin fails++; $display("FAIL both_b_ack got n=%0d rd=%h exp n=3 rd=2222", n, rd_data); end
    user_req = 0;
    idle(4);
  endtask

  task automatic test_user_write_critical();
    int n;
    user_we = 1; user_addr = 32'h44; user_wr_data = 16'h1234; user_wr_mask = 2'b10; user_req = 1;
    tick();
    tests++;
    if ({sd_enable, sd_we, sd_wr_mask} !== 4'b1110 || sd_addr !== 32'h44 || sd_wr_data !== 16'h1234) begin
      fails++; $display("FAIL uw_grant got=%b addr=%h wd=%h exp=1110 addr=44 wd=1234", {sd_enable, sd_we, sd_wr_mask}, sd_addr, sd_wr_data);
    end
    spi_critical = 1; spi_req = 1; spi_addr = 32'h50; user_wr_data = 16'hFFFF; user_wr_mask = 2'b01;
    #1;
    tests++;
    if (user_blocked !== 1'b0) begin fails++; $display("FAIL uw_not_blocked got=%b exp=0", user_blocked); end
    tick();
    tests++;
    if (sd_enable !== 1'b1 || sd_wr_mask !== 2'b10 || sd_wr_data !== 16'h1234) begin
      fails++; $display("FAIL uw_intact en=%b mask=%b wd=%h exp en=1 mask=10 wd=1234", sd_enable, sd_wr_mask, sd_wr_data);
    end
    wait_ack(1, 20, n);
    tests++;
    if (n !== 2) begin fails++; $display("FAIL uw_ack got=%0d exp=2", n); end
    user_req = 0; user_we = 0;
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (sd_enable === 1'b1) begin n = i; break; end
    end
    tests++;
    if (n !== 2 || sd_addr !== 32'h50 || sd_we !== 1'b0) begin fails++; $display("FAIL uw_a_next got n=%0d addr=%h we=%b exp n=2 addr=50 we=0", n, sd_addr, sd_we); end
    user_req = 1; user_addr = 32'h48; spi_refresh_inhibit = 1;
    #1;
    tests++;
    if ({user_blocked, sd_refresh_inhibit} !== 2'b11) begin fails++; $display("FAIL uw_blocked_inh got=%b exp=11", {user_blocked, sd_refresh_inhibit}); end
    wait_ack(0, 20, n);
    tests++;
    if (n !== 3) begin fails++; $display("FAIL uw_a_ack got=%0d exp=3", n); end
    spi_req = 0;
    idle(4);
    tests++;
    if ({sd_enable, user_blocked} !== 2'b01) begin fails++; $display("FAIL uw_held_off got=%b exp=01", {sd_enable, user_blocked}); end
    spi_critical = 0;
    #1;
    tests++;
    if ({user_blocked, sd_refresh_inhibit} !== 2'b00) begin fails++; $display("FAIL uw_unblock got=%b exp=00", {user_blocked, sd_refresh_inhibit}); end
    tick();
    tests++;
    if (sd_enable !== 1'b1 || sd_addr !== 32'h48 || sd_we !== 1'b0) begin fails++; $display("FAIL uw_b_grant en=%b addr=%h we=%b exp en=1 addr=48 we=0", sd_enable, sd_addr, sd_we); end
    wait_ack(1, 20, n);
    user_req = 0; spi_refresh_inhibit = 0;
    idle(4);
  endtask

  task automatic test_starvation();
    int found, acks, n;
    ctrl_lat = 3;
    spi_addr = 32'h66; user_addr = 32'h77; user_we = 0;
    spi_req = 1; user_req = 1;
    found = -1; acks = 0;
    // A access repeats every 5 cycles, 4 of which count toward the wait (RELEASE does not):
    // flag sets at cycle 79 (64th counted), B granted from the IDLE at cycle 81.
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (spi_ack === 1'b1) acks++;
      if (sd_enable === 1'b1 && sd_addr === 32'h77) begin found = i; break; end
    end
    tests++;
    if (found !== 81 || acks !== 16) begin fails++; $display("FAIL starve_grant got cyc=%0d acks=%0d exp cyc=81 acks=16", found, acks); end
    wait_ack(1, 20, n);
    tests++;
    if (n !== 3) begin fails++; $display("FAIL starve_b_ack got=%0d exp=3", n); end
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (sd_enable === 1'b1) begin n = i; break; end
    end
    tests++;
    if (n !== 2 || sd_addr !== 32'h66) begin fails++; $display("FAIL starve_oneshot got n=%0d addr=%h exp n=2 addr=66", n, sd_addr); end
    spi_req = 0; user_req = 0;
    idle(8);
  endtask

  task automatic test_drop();
    int n, uacks, ugrants;
    spi_addr = 32'h80; spi_req = 1;
    tick();
    tests++;
    if (sd_enable !== 1'b1 || sd_addr !== 32'h80) begin fails++; $display("FAIL drop_grant en=%b addr=%h exp en=1 addr=80", sd_enable, sd_addr); end
    spi_req = 0; user_req = 1; user_addr = 32'h99;
    tick();
    user_req = 0;
    wait_ack(0, 20, n);
    tests++;
    if (n !== 2) begin fails++; $display("FAIL drop_after_grant got=%0d exp=2", n); end
    uacks = 0; ugrants = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (user_ack === 1'b1) uacks++;
      if (sd_enable === 1'b1) ugrants++;
    end
    tests++;
    if (uacks !== 0 || ugrants !== 0) begin fails++; $display("FAIL drop_before_grant got acks=%0d grants=%0d exp 0 0", uacks, ugrants); end
  endtask

  task automatic test_timeout();
    int len, aborts, acks;
    logic prev;
    ctrl_on = 0; spi_addr = 32'hA0; spi_req = 1;
    tick();
    len = (sd_enable === 1'b1) ? 1 : 0;
    acks = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (spi_ack === 1'b1) acks++;
      if (sd_enable !== 1'b1) break;
      len++;
    end
    tests++;
    if (len !== 255 || error_count !== 8'd1 || acks !== 0) begin
      fails++; $display("FAIL timeout_first got len=%0d err=%0d acks=%0d exp len=255 err=1 acks=0", len, error_count, acks);
    end
    aborts = 0; prev = sd_enable;
    for (int i = 0; i < 300 * 260 && aborts < 300; i++) begin
      tick();
      if (spi_ack === 1'b1) acks++;
      if (prev === 1'b1 && sd_enable === 1'b0) aborts++;
      prev = sd_enable;
    end
    tests++;
    if (aborts !== 300 || error_count !== 8'd255 || acks !== 0) begin
      fails++; $display("FAIL timeout_saturate got aborts=%0d err=%0d acks=%0d exp 300 255 0", aborts, error_count, acks);
    end
    spi_req = 0;
    idle(3);
    ctrl_on = 1;
  endtask

  task automatic test_reset_mid_access();
    int n, acks;
    ctrl_on = 0; spi_addr = 32'hB0; spi_req = 1;
    tick();
    tests++;
    if (sd_enable !== 1'b1) begin fails++; $display("FAIL rstmid_grant got=%b exp=1", sd_enable); end
    #2 reset = 1;
    #1;
    tests++;
    if (sd_enable !== 1'b0 || error_count !== 8'd0 || sd_addr !== 32'h0) begin
      fails++; $display("FAIL rstmid_async en=%b err=%0d addr=%h exp 0 0 0", sd_enable, error_count, sd_addr);
    end
    spi_req = 0; ctrl_on = 1;
    acks = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (spi_ack === 1'b1) acks++;
    end
    #2 reset = 0;
    tick();
    if (spi_ack === 1'b1) acks++;
    tests++;
    if (sd_enable !== 1'b0 || acks !== 0) begin fails++; $display("FAIL rstmid_no_ack en=%b acks=%0d exp 0 0", sd_enable, acks); end
    ctrl_data = 16'h0C0C; spi_addr = 32'hC0; spi_req = 1;
    tick();
    tests++;
    if (sd_enable !== 1'b1 || sd_addr !== 32'hC0) begin fails++; $display("FAIL rstmid_idle_after en=%b addr=%h exp en=1 addr=c0", sd_enable, sd_addr); end
    wait_ack(0, 20, n);
    tests++;
    if (n !== 3 || rd_data !== 16'h0C0C) begin fails++; $display("FAIL rstmid_resume got n=%0d rd=%h exp n=3 rd=0c0c", n, rd_data); end
    spi_req = 0;
    idle(4);
  endtask

  initial begin
    test_reset();
    test_spi_read();
    test_both_rise();
    test_user_write_critical();
    test_starvation();
    test_drop();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
